pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_det.sv | 16 +
 rtl/pipe_ctrl.sv | 95 +++++++++
 tb/tb_pipe_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encoding, register constants and control bundle for pipe_ctrl
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;
  localparam logic [4:0] REG_X0 = 5'd0;
  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic ex_stall;
    logic if_flush;
    logic id_flush;
  } ctrl_t;
endpackage

// File: rtl/pipe_hazard_det.sv
// pipe_hazard_det: load-use comparator between the EX load destination and the ID sources
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_regwen,
  output logic       load_use
);
  assign load_use = ex_is_load & ex_regwen & (ex_rd != REG_X0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush control FSM for a 5-stage pipeline with memory-wait timeout and perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_regwen,
  input  logic             ex_br_mispred,
  input  logic             id_target_taken,
  input  logic             mem_wait,
  input  logic             wb_valid,
  input  logic             cnt_clr,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err
);
  localparam int WW = $clog2(STALL_TIMEOUT + 1);
  state_t        state, state_nxt;
  ctrl_t         ctl;
  logic          load_use;
  logic [WW-1:0] wcnt, wcnt_nxt;
  pipe_hazard_det u_haz (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_regwen  (ex_regwen),
    .load_use   (load_use)
  );
  // FLUSH means ID holds a bubble, so only a fresh mispredict matters there
  always_comb begin
    ctl       = '0;
    state_nxt = RUN;
    if (mem_wait) begin
      ctl.if_stall = 1'b1;
      ctl.id_stall = 1'b1;
      ctl.ex_stall = 1'b1;
      state_nxt    = MEMWAIT;
    end else if (ex_br_mispred) begin
      ctl.if_flush = 1'b1;
      ctl.id_flush = 1'b1;
      state_nxt    = FLUSH;
    end else if (state != FLUSH) begin
      if (load_use) begin
        ctl.if_stall = 1'b1;
        ctl.id_stall = 1'b1;
        ctl.id_flush = 1'b1;
      end else begin
        ctl.if_flush = id_target_taken;
      end
    end
  end
  assign if_stall = rst & ctl.if_stall;
  assign id_stall = rst & ctl.id_stall;
  assign ex_stall = rst & ctl.ex_stall;
  assign if_flush = rst & ctl.if_flush;
  assign id_flush = rst & ctl.id_flush;
  // wait counter restarts at 1 on MEMWAIT entry and saturates at the timeout
  assign wcnt_nxt = (state != MEMWAIT) ? WW'(1) :
                    (wcnt == WW'(STALL_TIMEOUT)) ? wcnt : wcnt + WW'(1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wcnt        <= '0;
      timeout_err <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      wcnt        <= mem_wait ? wcnt_nxt : wcnt;
      timeout_err <= cnt_clr ? 1'b0 : (timeout_err | (mem_wait & (wcnt_nxt == WW'(STALL_TIMEOUT))));
      cycle_cnt   <= cnt_clr ? '0 : cycle_cnt + CNT_W'(1);
      instret_cnt <= cnt_clr ? '0 : instret_cnt + CNT_W'(wb_valid);
      stall_cnt   <= cnt_clr ? '0 : stall_cnt + CNT_W'(if_stall);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl stall/flush priority, timeout and counters
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_regwen;
  logic        ex_br_mispred, id_target_taken, mem_wait, wb_valid, cnt_clr;
  logic        if_stall, id_stall, ex_stall, if_flush, id_flush, timeout_err;
  logic [31:0] cycle_cnt, instret_cnt, stall_cnt;
  int          checks = 0;
  int          errors = 0;
  wire  [4:0]  outs = {if_stall, id_stall, ex_stall, if_flush, id_flush};

  pipe_ctrl #(.STALL_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_regwen(ex_regwen),
    .ex_br_mispred(ex_br_mispred), .id_target_taken(id_target_taken),
    .mem_wait(mem_wait), .wb_valid(wb_valid), .cnt_clr(cnt_clr),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .if_flush(if_flush), .id_flush(id_flush),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_regwen = 0;
    ex_br_mispred = 0; id_target_taken = 0; mem_wait = 0; wb_valid = 0; cnt_clr = 0;
  endtask

  // EX: lw x5 ; ID: add x6,x5,x1
  task automatic lw_add();
    ex_is_load = 1; ex_regwen = 1; ex_rd = 5;
    id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    mem_wait = 1; ex_br_mispred = 1;
    #2;
    chk("rst_outs", outs, 5'b00000);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_err", timeout_err, 0);
    tick();
    chk("rst_hold_cycle", cycle_cnt, 0);
    idle();
    rst = 1;
    tick();
    chk("first_cycle", cycle_cnt, 1);

    lw_add(); #1;
    chk("lu_outs", outs, 5'b11001);
    tick();
    idle(); #1;
    chk("lu_after_outs", outs, 5'b00000);
    chk("lu_stall_cnt", stall_cnt, 1);

    ex_is_load = 1; ex_regwen = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #1;
    chk("x0_outs", outs, 5'b00000);
    idle(); ex_is_load = 1; ex_regwen = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; #1;
    chk("unused_rs1", outs, 5'b00000);
    id_rs2 = 7; id_use_rs2 = 1; #1;
    chk("rs2_match", outs, 5'b11001);
    ex_regwen = 0; #1;
    chk("no_regwen", outs, 5'b00000);
    idle(); lw_add(); id_target_taken = 1; #1;
    chk("lu_target", outs, 5'b11001);
    idle(); id_target_taken = 1; #1;
    chk("target_only", outs, 5'b00010);

    idle(); mem_wait = 1; ex_br_mispred = 1;
    for (int i = 0; i < 3; i++) begin
      #1; chk($sformatf("mw_mis_%0d", i), outs, 5'b11100);
      tick();
    end
    mem_wait = 0; #1;
    chk("mis_release", outs, 5'b00011);
    tick();
    ex_br_mispred = 0; lw_add(); id_target_taken = 1; #1;
    chk("flush_outs", outs, 5'b00000);
    tick(); #1;
    chk("run_after_flush", outs, 5'b11001);
    idle(); ex_br_mispred = 1;
    tick(); #1;
    chk("mis_in_flush", outs, 5'b00011);
    tick();

    idle(); cnt_clr = 1;
    tick();
    chk("clr_cycle", cycle_cnt, 0);
    chk("clr_stall", stall_cnt, 0);
    cnt_clr = 0; mem_wait = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("tmo_err_%0d", i), timeout_err, i >= 4);
    end
    chk("tmo_stall_cnt", stall_cnt, 6);
    mem_wait = 0; wb_valid = 1;
    tick();
    chk("tmo_sticky", timeout_err, 1);
    chk("tmo_cycle", cycle_cnt, 7);
    chk("tmo_instret", instret_cnt, 1);
    chk("tmo_stall_hold", stall_cnt, 6);
    wb_valid = 0; cnt_clr = 1;
    tick();
    chk("clr_err", timeout_err, 0);
    chk("clr_cycle2", cycle_cnt, 0);
    chk("clr_instret", instret_cnt, 0);
    chk("clr_stall2", stall_cnt, 0);

    idle(); ex_br_mispred = 1;
    tick();
    rst = 0; #1;
    chk("rstf_outs", outs, 5'b00000);
    chk("rstf_cycle", cycle_cnt, 0);
    tick();
    idle(); rst = 1; id_target_taken = 1; #1;
    chk("rstf_no_flush", outs, 5'b00010);
    tick();
    chk("rstf_cycle1", cycle_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
